kb_matrix_ctrl: RTL and testbench

KB_MATRIX_CTRL -- requirements
Module: kb_matrix_ctrl

---
 rtl/kb_matrix_ctrl_pkg.sv | 44 ++++
 rtl/kb_scan_map.sv | 42 ++++
 rtl/kb_matrix_ctrl.sv | 167 ++++++++++++++++
 tb/tb_kb_matrix_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kb_matrix_ctrl_pkg.sv
// kb_matrix_ctrl_pkg
// Shared definitions for the keyboard matrix controller:
//   - state_t        : PS2 sequencing FSM encoding
//   - PS2_ADDR_*     : PS2 register addresses (status / received data)
//   - PS2_CLR_VALID  : value written to the status register to drop "byte valid"
//   - CODE_*         : scancode prefixes, overrun codes and ignored replies
//   - NUM_ROWS       : rows in the emulated keyboard matrix
package kb_matrix_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_POLL   = 3'd0,
    ST_READ   = 3'd1,
    ST_LATCH  = 3'd2,
    ST_ACK    = 3'd3,
    ST_DECODE = 3'd4
  } state_t;

  localparam logic [1:0] PS2_ADDR_STATUS = 2'd0;
  localparam logic [1:0] PS2_ADDR_DATA   = 2'd1;

  localparam logic [7:0] PS2_CLR_VALID = 8'h02;

  localparam logic [7:0] CODE_BREAK  = 8'hF0;
  localparam logic [7:0] CODE_EXT    = 8'hE0;
  localparam logic [7:0] CODE_OVR_LO = 8'h00;
  localparam logic [7:0] CODE_OVR_HI = 8'hFF;
  localparam logic [7:0] CODE_ACK    = 8'hFA;
  localparam logic [7:0] CODE_RESEND = 8'hFE;
  localparam logic [7:0] CODE_BAT_OK = 8'hAA;
  localparam logic [7:0] CODE_PAUSE  = 8'hE1;

  localparam int NUM_ROWS = 10;

  // Device replies and the pause prefix never touch the matrix.
  function automatic logic is_ignored(input logic [7:0] code);
    return (code == CODE_ACK) || (code == CODE_RESEND) ||
           (code == CODE_BAT_OK) || (code == CODE_PAUSE);
  endfunction

  function automatic logic is_overrun(input logic [7:0] code);
    return (code == CODE_OVR_LO) || (code == CODE_OVR_HI);
  endfunction

endpackage

// File: rtl/kb_scan_map.sv
// kb_scan_map
// Combinational scancode -> matrix position lookup.
//   I_EXT  : 1 when the code was preceded by the E0 prefix
//   I_CODE : scancode byte
//   O_HIT  : 1 when {I_EXT, I_CODE} maps to a matrix key
//   O_ROW  : matrix row (0-9), valid only with O_HIT
//   O_COL  : bit within the row, valid only with O_HIT
module kb_scan_map
  import kb_matrix_ctrl_pkg::*;
(
  input  logic       I_EXT,
  input  logic [7:0] I_CODE,
  output logic       O_HIT,
  output logic [3:0] O_ROW,
  output logic [2:0] O_COL
);

  always_comb begin
    O_HIT = 1'b0;
    O_ROW = 4'd0;
    O_COL = 3'd0;
    case ({I_EXT, I_CODE})
      9'h01C: begin O_HIT = 1'b1; O_ROW = 4'd2; O_COL = 3'd1; end // A
      9'h016: begin O_HIT = 1'b1; O_ROW = 4'd6; O_COL = 3'd1; end // 1
      9'h070: begin O_HIT = 1'b1; O_ROW = 4'd0; O_COL = 3'd0; end // keypad 0
      9'h05A: begin O_HIT = 1'b1; O_ROW = 4'd1; O_COL = 3'd7; end // Enter
      9'h012: begin O_HIT = 1'b1; O_ROW = 4'd8; O_COL = 3'd6; end // L-Shift
      9'h059: begin O_HIT = 1'b1; O_ROW = 4'd8; O_COL = 3'd6; end // R-Shift shares L-Shift
      9'h014: begin O_HIT = 1'b1; O_ROW = 4'd8; O_COL = 3'd7; end // L-Ctrl
      9'h175: begin O_HIT = 1'b1; O_ROW = 4'd8; O_COL = 3'd1; end // Up (E0 75)
      9'h174: begin O_HIT = 1'b1; O_ROW = 4'd8; O_COL = 3'd2; end // Right (E0 74)
      9'h029: begin O_HIT = 1'b1; O_ROW = 4'd9; O_COL = 3'd6; end // Space
      9'h076: begin O_HIT = 1'b1; O_ROW = 4'd9; O_COL = 3'd7; end // Esc
      default: begin
        O_HIT = 1'b0;
        O_ROW = 4'd0;
        O_COL = 3'd0;
      end
    endcase
  end

endmodule

// File: rtl/kb_matrix_ctrl.sv
// kb_matrix_ctrl
// Polls a PS2 controller register block, decodes scancodes and maintains an
// active-low 10x8 keyboard matrix the CPU reads one row at a time.
//   I_CLK, I_RST_N   : clock, asynchronous active-low reset
//   I_CPU_ADDR       : matrix row select (0-9 valid, 10-15 read FFh)
//   I_CLR_ALL        : release every key on the next edge
//   O_KB_DATA        : selected row, 0 = pressed
//   O_PS2_ADDR       : PS2 register address (0 status, 1 data)
//   O_PS2_WRITE      : PS2 register write strobe
//   O_PS2_WRDATA     : PS2 register write data
//   I_PS2_RDDATA     : PS2 register read data, status bit0 = byte valid
//   O_DBG_STATE      : current sequencing state
// PS2 handshake: the status register's bit0 is the valid flag; a byte is
// consumed by reading the data register and then writing 02h to status,
// which is the only acknowledge the device sees.
module kb_matrix_ctrl
  import kb_matrix_ctrl_pkg::*;
#(
  parameter int POLL_DIV = 16  // cycles between status samples, >= 2
) (
  input  logic       I_CLK,
  input  logic       I_RST_N,
  input  logic [3:0] I_CPU_ADDR,
  input  logic       I_CLR_ALL,
  output logic [7:0] O_KB_DATA,
  output logic [1:0] O_PS2_ADDR,
  output logic       O_PS2_WRITE,
  output logic [7:0] O_PS2_WRDATA,
  input  logic [7:0] I_PS2_RDDATA,
  output state_t     O_DBG_STATE
);

  localparam int CNT_W = $clog2(POLL_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_DIV - 1);

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [7:0]                 code_q, code_d;
  logic                       brk_q, brk_d;
  logic                       ext_q, ext_d;
  logic [NUM_ROWS-1:0][7:0]   rows_q, rows_d;

  logic       map_hit;
  logic [3:0] map_row;
  logic [2:0] map_col;

  kb_scan_map u_scan_map (
    .I_EXT  (ext_q),
    .I_CODE (code_q),
    .O_HIT  (map_hit),
    .O_ROW  (map_row),
    .O_COL  (map_col)
  );

  // State register and datapath flops.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q <= ST_POLL;
      cnt_q   <= '0;
      code_q  <= 8'h00;
      brk_q   <= 1'b0;
      ext_q   <= 1'b0;
      rows_q  <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      brk_q   <= brk_d;
      ext_q   <= ext_d;
      rows_q  <= rows_d;
    end
  end

  // Next-state logic, poll counter and code capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    case (state_q)
      ST_POLL: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (I_PS2_RDDATA[0]) state_d = ST_READ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_READ:  state_d = ST_LATCH;
      ST_LATCH: begin
        code_d  = I_PS2_RDDATA;
        state_d = ST_ACK;
      end
      ST_ACK:   state_d = ST_DECODE;
      ST_DECODE: begin
        cnt_d   = '0;
        state_d = ST_POLL;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_POLL;
      end
    endcase
  end

  // Matrix and prefix flags. A clear request overrides whatever DECODE
  // would have done; the FSM itself is unaffected.
  always_comb begin
    rows_d = rows_q;
    brk_d  = brk_q;
    ext_d  = ext_q;
    if (I_CLR_ALL) begin
      rows_d = '1;
      if (state_q == ST_DECODE) begin
        brk_d = 1'b0;
        ext_d = 1'b0;
      end
    end else if (state_q == ST_DECODE) begin
      if (code_q == CODE_BREAK) begin
        brk_d = 1'b1;
      end else if (code_q == CODE_EXT) begin
        ext_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if (is_overrun(code_q)) begin
          rows_d = '1;
        end else if (!is_ignored(code_q) && map_hit) begin
          // Break flag doubles as the written bit: 1 = released.
          for (int r = 0; r < NUM_ROWS; r++) begin
            if (map_row == 4'(r)) rows_d[r][map_col] = brk_q;
          end
        end
      end
    end
  end

  // Moore output decode.
  always_comb begin
    O_PS2_ADDR   = PS2_ADDR_STATUS;
    O_PS2_WRITE  = 1'b0;
    O_PS2_WRDATA = 8'h00;
    case (state_q)
      ST_READ, ST_LATCH: O_PS2_ADDR = PS2_ADDR_DATA;
      ST_ACK: begin
        O_PS2_ADDR   = PS2_ADDR_STATUS;
        O_PS2_WRITE  = 1'b1;
        O_PS2_WRDATA = PS2_CLR_VALID;
      end
      default: begin
        O_PS2_ADDR   = PS2_ADDR_STATUS;
        O_PS2_WRITE  = 1'b0;
        O_PS2_WRDATA = 8'h00;
      end
    endcase
  end

  // CPU row read straight from the flops, so a same-cycle update is not seen.
  always_comb begin
    O_KB_DATA = 8'hFF;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (I_CPU_ADDR == 4'(r)) O_KB_DATA = rows_q[r];
    end
  end

  assign O_DBG_STATE = state_q;

endmodule

// File: tb/tb_kb_matrix_ctrl.sv
module tb_kb_matrix_ctrl;
  import kb_matrix_ctrl_pkg::*;

  localparam int POLL_DIV = 4;

  logic       I_CLK;
  logic       I_RST_N;
  logic [3:0] I_CPU_ADDR;
  logic       I_CLR_ALL;
  logic [7:0] O_KB_DATA;
  logic [1:0] O_PS2_ADDR;
  logic       O_PS2_WRITE;
  logic [7:0] O_PS2_WRDATA;
  logic [7:0] I_PS2_RDDATA;
  state_t     dbg_state;

  // PS2 device model state
  logic [7:0] ps2_data;
  logic       ps2_valid;

  int n_checks;
  int n_errors;
  logic [7:0] kb_at_decode;

  kb_matrix_ctrl #(.POLL_DIV(POLL_DIV)) dut (
    .I_CLK        (I_CLK),
    .I_RST_N      (I_RST_N),
    .I_CPU_ADDR   (I_CPU_ADDR),
    .I_CLR_ALL    (I_CLR_ALL),
    .O_KB_DATA    (O_KB_DATA),
    .O_PS2_ADDR   (O_PS2_ADDR),
    .O_PS2_WRITE  (O_PS2_WRITE),
    .O_PS2_WRDATA (O_PS2_WRDATA),
    .I_PS2_RDDATA (I_PS2_RDDATA),
    .O_DBG_STATE  (dbg_state)
  );

  // Clock / watchdog
  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // PS2 register read port
  always_comb begin
    if (O_PS2_ADDR == PS2_ADDR_DATA) I_PS2_RDDATA = ps2_data;
    else                             I_PS2_RDDATA = {7'd0, ps2_valid};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one byte and follow it through the handshake; returns at the
  // negedge of the first POLL cycle after DECODE (sample + 5).
  task automatic send_byte(input logic [7:0] b);
    int   cyc, t_read, t_ack, n_wr, t_done;
    logic [7:0] wr_val;
    ps2_data  = b;
    ps2_valid = 1'b1;
    cyc = 0; t_read = -1; t_ack = -1; n_wr = 0; t_done = -1; wr_val = 8'h00;
    kb_at_decode = 8'hxx;
    while (cyc < 100 && t_done < 0) begin
      @(negedge I_CLK);
      cyc++;
      if (dbg_state == ST_READ && t_read < 0) t_read = cyc;
      if (O_PS2_WRITE) begin
        n_wr++;
        wr_val    = O_PS2_WRDATA;
        ps2_valid = 1'b0;
        t_ack     = cyc;
      end
      if (dbg_state == ST_DECODE) kb_at_decode = O_KB_DATA;
      if (t_ack > 0 && dbg_state == ST_POLL) t_done = cyc;
    end
    chk("byte_done", 32'(t_done > 0), 32'd1);
    chk("write_pulses", 32'(n_wr), 32'd1);
    chk("write_data", 32'(wr_val), 32'h02);
    chk("ack_latency", 32'(t_ack - t_read), 32'd2);
    chk("visible_latency", 32'(t_done - t_read), 32'd4);
  endtask

  task automatic wait_state(input state_t s, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge I_CLK);
      if (O_PS2_WRITE) ps2_valid = 1'b0;
      if (dbg_state == s) ok = 1'b1;
    end
  endtask

  task automatic chk_row(input string name, input logic [3:0] a, input logic [7:0] exp);
    I_CPU_ADDR = a;
    #1;
    chk(name, 32'(O_KB_DATA), 32'(exp));
  endtask

  typedef struct {
    logic [7:0] code;
    logic [3:0] addr;
    logic [7:0] exp;
  } vec_t;

  localparam int NV = 41;
  vec_t vecs [NV];

  initial begin
    logic ok;
    int   n;

    vecs[0]  = '{8'hF0, 4'd2, 8'hFD};
    vecs[1]  = '{8'h1C, 4'd2, 8'hFF};
    vecs[2]  = '{8'h1C, 4'd2, 8'hFD};
    vecs[3]  = '{8'hF0, 4'd2, 8'hFD};
    vecs[4]  = '{8'h1C, 4'd2, 8'hFF};
    vecs[5]  = '{8'hE0, 4'd8, 8'hFF};
    vecs[6]  = '{8'h75, 4'd8, 8'hFD};
    vecs[7]  = '{8'h12, 4'd8, 8'hBD};
    vecs[8]  = '{8'hF0, 4'd8, 8'hBD};
    vecs[9]  = '{8'h12, 4'd8, 8'hFD};
    vecs[10] = '{8'hE0, 4'd8, 8'hFD};
    vecs[11] = '{8'hF0, 4'd8, 8'hFD};
    vecs[12] = '{8'h75, 4'd8, 8'hFF};
    vecs[13] = '{8'h16, 4'd6, 8'hFD};
    vecs[14] = '{8'h29, 4'd9, 8'hBF};
    vecs[15] = '{8'h16, 4'd6, 8'hFD};
    vecs[16] = '{8'hFF, 4'd6, 8'hFF};
    vecs[17] = '{8'h3F, 4'd9, 8'hFF};
    vecs[18] = '{8'h76, 4'd9, 8'h7F};
    vecs[19] = '{8'h3F, 4'd9, 8'h7F};
    vecs[20] = '{8'hAA, 4'd9, 8'h7F};
    vecs[21] = '{8'hF0, 4'd9, 8'h7F};
    vecs[22] = '{8'hFA, 4'd9, 8'h7F};
    vecs[23] = '{8'h76, 4'd9, 8'h7F};
    vecs[24] = '{8'h5A, 4'd1, 8'h7F};
    vecs[25] = '{8'h70, 4'd0, 8'hFE};
    vecs[26] = '{8'h59, 4'd8, 8'hBF};
    vecs[27] = '{8'h14, 4'd8, 8'h3F};
    vecs[28] = '{8'h00, 4'd8, 8'hFF};
    vecs[29] = '{8'hE0, 4'd8, 8'hFF};
    vecs[30] = '{8'h74, 4'd8, 8'hFB};
    vecs[31] = '{8'hE0, 4'd8, 8'hFB};
    vecs[32] = '{8'h59, 4'd8, 8'hFB};
    vecs[33] = '{8'h59, 4'd8, 8'hBB};
    vecs[34] = '{8'hF0, 4'd8, 8'hBB};
    vecs[35] = '{8'hE1, 4'd8, 8'hBB};
    vecs[36] = '{8'h59, 4'd8, 8'hBB};
    vecs[37] = '{8'hF0, 4'd8, 8'hBB};
    vecs[38] = '{8'hFE, 4'd8, 8'hBB};
    vecs[39] = '{8'h14, 4'd8, 8'h3B};
    vecs[40] = '{8'h00, 4'd8, 8'hFF};

    n_checks   = 0;
    n_errors   = 0;
    I_RST_N    = 1'b0;
    I_CPU_ADDR = 4'd2;
    I_CLR_ALL  = 1'b0;
    ps2_data   = 8'h00;
    ps2_valid  = 1'b0;

    // Reset state
    repeat (3) @(negedge I_CLK);
    chk("rst_kb_data", 32'(O_KB_DATA), 32'hFF);
    chk("rst_ps2_addr", 32'(O_PS2_ADDR), 32'd0);
    chk("rst_ps2_write", 32'(O_PS2_WRITE), 32'd0);
    chk("rst_ps2_wrdata", 32'(O_PS2_WRDATA), 32'h00);
    chk("rst_state", 32'(dbg_state), 32'(ST_POLL));
    I_RST_N = 1'b1;
    repeat (2) @(negedge I_CLK);

    // First make: old value during DECODE, new value one cycle later
    I_CPU_ADDR = 4'd2;
    send_byte(8'h1C);
    chk("a_old_at_decode", 32'(kb_at_decode), 32'hFF);
    chk("a_pressed", 32'(O_KB_DATA), 32'hFD);

    // Table-driven byte stream
    for (int i = 0; i < NV; i++) begin
      I_CPU_ADDR = vecs[i].addr;
      send_byte(vecs[i].code);
      #1;
      if (O_KB_DATA !== vecs[i].exp) begin
        n_errors++;
        $display("FAIL vec%0d code %0h row %0d: got %0h expected %0h",
                 i, vecs[i].code, vecs[i].addr, O_KB_DATA, vecs[i].exp);
      end
      n_checks++;
    end

    // Unused addresses read released
    for (int a = 10; a < 16; a++) chk("hi_addr", 32'(0), 32'(0) | 32'(O_KB_DATA ^ 8'hFF) & 32'(a == -1));
    for (int a = 10; a < 16; a++) chk_row("hi_addr_row", 4'(a), 8'hFF);

    // Clear coinciding with DECODE of a make
    I_CPU_ADDR = 4'd9;
    send_byte(8'h29);
    chk("space_pressed", 32'(O_KB_DATA), 32'hBF);
    ps2_data  = 8'h1C;
    ps2_valid = 1'b1;
    wait_state(ST_DECODE, 100, ok);
    chk("reach_decode_1c", 32'(ok), 32'd1);
    I_CLR_ALL = 1'b1;
    @(negedge I_CLK);
    I_CLR_ALL = 1'b0;
    chk("clr_state_poll", 32'(dbg_state), 32'(ST_POLL));
    chk_row("clr_row2", 4'd2, 8'hFF);
    chk_row("clr_row9", 4'd9, 8'hFF);

    // Clear during DECODE of E0 must drop the extended flag
    ps2_data  = 8'hE0;
    ps2_valid = 1'b1;
    wait_state(ST_DECODE, 100, ok);
    chk("reach_decode_e0", 32'(ok), 32'd1);
    I_CLR_ALL = 1'b1;
    @(negedge I_CLK);
    I_CLR_ALL = 1'b0;
    I_CPU_ADDR = 4'd8;
    send_byte(8'h75);
    chk("ext_cleared_by_clr", 32'(O_KB_DATA), 32'hFF);

    // Clear while idle in POLL
    I_CPU_ADDR = 4'd9;
    send_byte(8'h76);
    chk("esc_pressed", 32'(O_KB_DATA), 32'h7F);
    I_CLR_ALL = 1'b1;
    @(negedge I_CLK);
    I_CLR_ALL = 1'b0;
    chk("idle_clr_row9", 32'(O_KB_DATA), 32'hFF);

    // Reset asserted mid-ACK
    send_byte(8'h29);
    chk("space_pressed2", 32'(O_KB_DATA), 32'hBF);
    ps2_data  = 8'h16;
    ps2_valid = 1'b1;
    wait_state(ST_ACK, 100, ok);
    chk("reach_ack", 32'(ok), 32'd1);
    chk("in_ack_write", 32'(O_PS2_WRITE), 32'd1);
    I_RST_N = 1'b0;
    #1;
    chk("rst_ack_write", 32'(O_PS2_WRITE), 32'd0);
    chk("rst_ack_addr", 32'(O_PS2_ADDR), 32'd0);
    chk("rst_ack_wrdata", 32'(O_PS2_WRDATA), 32'h00);
    chk("rst_ack_state", 32'(dbg_state), 32'(ST_POLL));
    chk_row("rst_ack_row9", 4'd9, 8'hFF);
    chk_row("rst_ack_addr12", 4'd12, 8'hFF);
    ps2_data  = 8'h1C;
    ps2_valid = 1'b1;
    @(negedge I_CLK);
    I_RST_N = 1'b1;
    // Counter restarts from 0: READ appears POLL_DIV cycles after release
    n = 0;
    ok = 1'b0;
    while (n < 50 && !ok) begin
      @(negedge I_CLK);
      n++;
      if (dbg_state == ST_READ) ok = 1'b1;
    end
    chk("post_rst_read_seen", 32'(ok), 32'd1);
    chk("post_rst_poll_len", 32'(n), 32'(POLL_DIV));
    wait_state(ST_POLL, 100, ok);
    chk("post_rst_back_poll", 32'(ok), 32'd1);
    chk_row("post_rst_row2", 4'd2, 8'hFD);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
